// File: rtl/axi_burst_tester.sv
// axi_burst_tester: AXI4 write-then-readback memory test master.
// Ports: clk_clk, reset_reset (async, active-high), start/busy/done/pass,
//   err_count, first_err_addr, and one full AXI4 master (m_aw*, m_w*,
//   m_b*, m_ar*, m_r*) for a 16-bit word-addressed responder.
// Build option: AXI_TESTER_LFSR_EN selects a 16-bit Fibonacci LFSR
//   pattern; otherwise pattern(addr) = addr[15:0] ^ SEED.
module axi_burst_tester #(
   parameter logic [21:0] BASE_ADDR  = 22'h000000,
   parameter int          BURST_LEN  = 16,
   parameter int          NUM_BURSTS = 64,
   parameter logic [7:0]  AXI_ID     = 8'h00,
   parameter logic [15:0] SEED       = 16'hACE1
) (
   input  logic        clk_clk,
   input  logic        reset_reset,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] err_count,
   output logic [21:0] first_err_addr,
   output logic [7:0]  m_awid,
   output logic [21:0] m_awaddr,
   output logic [7:0]  m_awlen,
   output logic [2:0]  m_awsize,
   output logic [1:0]  m_awburst,
   output logic        m_awvalid,
   input  logic        m_awready,
   output logic [15:0] m_wdata,
   output logic [1:0]  m_wstrb,
   output logic        m_wlast,
   output logic        m_wvalid,
   input  logic        m_wready,
   input  logic [7:0]  m_bid,
   input  logic [1:0]  m_bresp,
   input  logic        m_bvalid,
   output logic        m_bready,
   output logic [7:0]  m_arid,
   output logic [21:0] m_araddr,
   output logic [7:0]  m_arlen,
   output logic [2:0]  m_arsize,
   output logic [1:0]  m_arburst,
   output logic        m_arvalid,
   input  logic        m_arready,
   input  logic [7:0]  m_rid,
   input  logic [15:0] m_rdata,
   input  logic [1:0]  m_rresp,
   input  logic        m_rlast,
   input  logic        m_rvalid,
   output logic        m_rready
);

   typedef enum logic [2:0] {
      S_IDLE, S_WA, S_WD, S_WB, S_RA, S_RD, S_FIN
   } state_t;

   localparam logic [7:0]  LAST_BEAT  = 8'(BURST_LEN - 1);
   localparam logic [15:0] LAST_BURST = 16'(NUM_BURSTS - 1);
   localparam logic [21:0] STRIDE     = 22'(BURST_LEN);

   state_t      state;
   logic [7:0]  beat_idx;
   logic [15:0] burst_idx;
   logic [21:0] burst_addr;
   logic [21:0] beat_addr;
   logic [15:0] pat;
   logic        pat_load;
   logic        pat_step;
   logic        b_bad;
   logic        r_bad;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Pattern source restarts at test start and again when the read
   // phase begins; it advances once per W beat loaded and R beat taken.
   assign pat_load = (state == S_IDLE && start) ||
                     (state == S_WB && m_bvalid &&
                      burst_idx == LAST_BURST);
   assign pat_step = (state == S_WA && m_awvalid && m_awready) ||
                     (state == S_WD && m_wvalid && m_wready &&
                      !m_wlast) ||
                     (state == S_RD && m_rvalid);

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset)   beat_addr <= 22'h0;
      else if (pat_load) beat_addr <= BASE_ADDR;
      else if (pat_step) beat_addr <= beat_addr + 22'd1;
   end

`ifdef AXI_TESTER_LFSR_EN
   logic [15:0] lfsr;

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset)   lfsr <= 16'h0;
      else if (pat_load) lfsr <= SEED;
      else if (pat_step)
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end

   assign pat = lfsr;
`else
   assign pat = beat_addr[15:0] ^ SEED;
`endif

   assign b_bad = (m_bresp != 2'b00) || (m_bid != AXI_ID);
   assign r_bad = (m_rdata != pat) || (m_rresp != 2'b00) ||
                  (m_rid != AXI_ID) ||
                  (m_rlast != (beat_idx == LAST_BEAT));

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         state          <= S_IDLE;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         err_count      <= 16'h0;
         first_err_addr <= 22'h0;
         beat_idx       <= 8'h0;
         burst_idx      <= 16'h0;
         burst_addr     <= 22'h0;
         m_awid         <= 8'h0;
         m_awaddr       <= 22'h0;
         m_awlen        <= 8'h0;
         m_awsize       <= 3'h0;
         m_awburst      <= 2'h0;
         m_awvalid      <= 1'b0;
         m_wdata        <= 16'h0;
         m_wstrb        <= 2'h0;
         m_wlast        <= 1'b0;
         m_wvalid       <= 1'b0;
         m_bready       <= 1'b0;
         m_arid         <= 8'h0;
         m_araddr       <= 22'h0;
         m_arlen        <= 8'h0;
         m_arsize       <= 3'h0;
         m_arburst      <= 2'h0;
         m_arvalid      <= 1'b0;
         m_rready       <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  busy           <= 1'b1;
                  done           <= 1'b0;
                  pass           <= 1'b0;
                  err_count      <= 16'h0;
                  first_err_addr <= 22'h0;
                  m_awid         <= AXI_ID;
                  m_arid         <= AXI_ID;
                  m_awlen        <= LAST_BEAT;
                  m_arlen        <= LAST_BEAT;
                  m_awsize       <= 3'b001;
                  m_arsize       <= 3'b001;
                  m_awburst      <= 2'b01;
                  m_arburst      <= 2'b01;
                  m_wstrb        <= 2'b11;
                  burst_idx      <= 16'h0;
                  burst_addr     <= BASE_ADDR;
                  m_awaddr       <= BASE_ADDR;
                  m_awvalid      <= 1'b1;
                  state          <= S_WA;
               end
            end
            S_WA: begin
               if (m_awready) begin
                  m_awvalid <= 1'b0;
                  m_wvalid  <= 1'b1;
                  m_wdata   <= pat;
                  m_wlast   <= (LAST_BEAT == 8'd0);
                  beat_idx  <= 8'h0;
                  state     <= S_WD;
               end
            end
            S_WD: begin
               if (m_wready) begin
                  if (m_wlast) begin
                     m_wvalid <= 1'b0;
                     m_wlast  <= 1'b0;
                     m_bready <= 1'b1;
                     state    <= S_WB;
                  end else begin
                     beat_idx <= beat_idx + 8'd1;
                     m_wdata  <= pat;
                     m_wlast  <= (beat_idx + 8'd1 == LAST_BEAT);
                  end
               end
            end
            S_WB: begin
               if (m_bvalid) begin
                  m_bready <= 1'b0;
                  if (b_bad) begin
                     err_count <= sat_inc(err_count);
                     if (err_count == 16'h0)
                        first_err_addr <= burst_addr;
                  end
                  if (burst_idx == LAST_BURST) begin
                     // arvalid is raised from RA, leaving one idle
                     // cycle between the phases
                     burst_idx  <= 16'h0;
                     burst_addr <= BASE_ADDR;
                     state      <= S_RA;
                  end else begin
                     burst_idx  <= burst_idx + 16'd1;
                     burst_addr <= burst_addr + STRIDE;
                     m_awaddr   <= burst_addr + STRIDE;
                     m_awvalid  <= 1'b1;
                     state      <= S_WA;
                  end
               end
            end
            S_RA: begin
               if (!m_arvalid) begin
                  m_arvalid <= 1'b1;
                  m_araddr  <= burst_addr;
               end else if (m_arready) begin
                  m_arvalid <= 1'b0;
                  m_rready  <= 1'b1;
                  beat_idx  <= 8'h0;
                  state     <= S_RD;
               end
            end
            S_RD: begin
               if (m_rvalid) begin
                  if (r_bad) begin
                     err_count <= sat_inc(err_count);
                     if (err_count == 16'h0)
                        first_err_addr <= beat_addr;
                  end
                  if (beat_idx == LAST_BEAT) begin
                     m_rready <= 1'b0;
                     if (burst_idx == LAST_BURST) begin
                        state <= S_FIN;
                     end else begin
                        burst_idx  <= burst_idx + 16'd1;
                        burst_addr <= burst_addr + STRIDE;
                        m_araddr   <= burst_addr + STRIDE;
                        m_arvalid  <= 1'b1;
                        state      <= S_RA;
                     end
                  end else begin
                     beat_idx <= beat_idx + 8'd1;
                  end
               end
            end
            S_FIN: begin
               busy  <= 1'b0;
               done  <= 1'b1;
               pass  <= (err_count == 16'h0);
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_burst_tester.sv
// tb_axi_burst_tester: two tester instances (small region at 0, and a
// region wrapping the top of the 22-bit space) against a queue memory.
module tb_axi_burst_tester;

   localparam logic [7:0]  ID   = 8'h3C;
   localparam logic [15:0] SEED = 16'hACE1;
   localparam int          MASK = 32'h003F_FFFF;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst [2], start [2], busy [2], done [2], pass [2];
   logic [15:0] err_count [2];
   logic [21:0] fea [2];
   logic [7:0]  awid [2], awlen [2], arid [2], arlen [2];
   logic [21:0] awaddr [2], araddr [2];
   logic [2:0]  awsize [2], arsize [2];
   logic [1:0]  awburst [2], arburst [2], wstrb [2], bresp [2], rresp [2];
   logic        awvalid [2], awready [2], wlast [2], wvalid [2];
   logic        wready [2], bvalid [2], bready [2], arvalid [2];
   logic        arready [2], rlast [2], rvalid [2], rready [2];
   logic [15:0] wdata [2], rdata [2];
   logic [7:0]  bid [2], rid [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      axi_burst_tester #(
         .BASE_ADDR  (g == 0 ? 22'h000000 : 22'h3FFFFC),
         .BURST_LEN  (g == 0 ? 4 : 8),
         .NUM_BURSTS (g == 0 ? 2 : 1),
         .AXI_ID     (ID),
         .SEED       (SEED)
      ) u_dut (
         .clk_clk        (clk),
         .reset_reset    (rst[g]),
         .start          (start[g]),
         .busy           (busy[g]),
         .done           (done[g]),
         .pass           (pass[g]),
         .err_count      (err_count[g]),
         .first_err_addr (fea[g]),
         .m_awid         (awid[g]),
         .m_awaddr       (awaddr[g]),
         .m_awlen        (awlen[g]),
         .m_awsize       (awsize[g]),
         .m_awburst      (awburst[g]),
         .m_awvalid      (awvalid[g]),
         .m_awready      (awready[g]),
         .m_wdata        (wdata[g]),
         .m_wstrb        (wstrb[g]),
         .m_wlast        (wlast[g]),
         .m_wvalid       (wvalid[g]),
         .m_wready       (wready[g]),
         .m_bid          (bid[g]),
         .m_bresp        (bresp[g]),
         .m_bvalid       (bvalid[g]),
         .m_bready       (bready[g]),
         .m_arid         (arid[g]),
         .m_araddr       (araddr[g]),
         .m_arlen        (arlen[g]),
         .m_arsize       (arsize[g]),
         .m_arburst      (arburst[g]),
         .m_arvalid      (arvalid[g]),
         .m_arready      (arready[g]),
         .m_rid          (rid[g]),
         .m_rdata        (rdata[g]),
         .m_rresp        (rresp[g]),
         .m_rlast        (rlast[g]),
         .m_rvalid       (rvalid[g]),
         .m_rready       (rready[g])
      );
   end

   int checks = 0;
   int errors = 0;
   logic [15:0] mem [int];
   int aw_log [$];
   int ar_log [$];
   int wl_log [$];
   int stab;
   int proto;

   function automatic int bl_of(input int d);
      return d == 0 ? 4 : 8;
   endfunction

   function automatic int nb_of(input int d);
      return d == 0 ? 2 : 1;
   endfunction

   function automatic int base_of(input int d);
      return d == 0 ? 0 : 32'h003F_FFFC;
   endfunction

   // Expected data word for address a of instance d.
   function automatic logic [15:0] pat_of(input int d, input int a);
      logic [15:0] v;
      int n;
`ifdef AXI_TESTER_LFSR_EN
      v = SEED;
      n = (a - base_of(d)) & MASK;
      for (int i = 0; i < n; i++)
         v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
`else
      n = d;
      v = a[15:0] ^ SEED;
`endif
      return v;
   endfunction

   function automatic logic [255:0] outs(input int d);
      return 256'({busy[d], done[d], pass[d], err_count[d], fea[d],
                   awid[d], awaddr[d], awlen[d], awsize[d], awburst[d],
                   awvalid[d], wdata[d], wstrb[d], wlast[d], wvalid[d],
                   bready[d], arid[d], araddr[d], arlen[d], arsize[d],
                   arburst[d], arvalid[d], rready[d]});
   endfunction

   // Memory responder. Everything is sampled/driven on negedges; a
   // handshake seen at a negedge completes on the following posedge.
   task automatic serve(input int d, input bit stall, input int bad_word,
                        input int bad_b, input int restart_at,
                        input bit abort_wd,
                        output bit timed_out, output bit busy1);
      int wq [$];
      int rq [$];
      int bl, a, wbeat, rbeat, wtot, b_pend, b_cnt, aw_w, w_w, ar_w;
      bit p_aw, p_w, p_b, p_ar, p_r, p_awv, p_wv, p_arv;
      logic [21:0] p_awaddr, p_araddr;
      logic [15:0] p_wdata;
      logic        p_wlast;
      bl = bl_of(d);
      wbeat = 0; rbeat = 0; wtot = 0; b_pend = 0; b_cnt = 0;
      aw_w = 0; w_w = 0; ar_w = 0;
      p_aw = 0; p_w = 0; p_b = 0; p_ar = 0; p_r = 0;
      p_awv = 0; p_wv = 0; p_arv = 0;
      p_awaddr = '0; p_araddr = '0; p_wdata = '0; p_wlast = 0;
      aw_log.delete(); ar_log.delete(); wl_log.delete();
      stab = 0; proto = 0;
      timed_out = 1; busy1 = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         if (p_aw) begin
            aw_log.push_back(int'(p_awaddr));
            wq.push_back(int'(p_awaddr));
            if (stall) aw_w = $urandom_range(0, 7);
         end
         if (p_w) begin
            if (stall) w_w = $urandom_range(0, 7);
            if (wq.size() == 0) proto++;
            else begin
               mem[(wq[0] + wbeat) & MASK] = p_wdata;
               if (p_wlast) wl_log.push_back(wtot);
               wtot++;
               wbeat++;
               if (wbeat == bl) begin
                  wbeat = 0;
                  void'(wq.pop_front());
                  b_pend++;
               end
            end
         end
         if (p_b) bvalid[d] = 0;
         if (p_ar) begin
            ar_log.push_back(int'(p_araddr));
            rq.push_back(int'(p_araddr));
            if (stall) ar_w = $urandom_range(0, 7);
         end
         if (p_r) begin
            rbeat++;
            if (rbeat == bl) begin
               rbeat = 0;
               void'(rq.pop_front());
            end
         end
         if (p_awv && !p_aw && (!awvalid[d] || awaddr[d] != p_awaddr))
            stab++;
         if (p_wv && !p_w && (!wvalid[d] || wdata[d] != p_wdata ||
                              wlast[d] != p_wlast))
            stab++;
         if (p_arv && !p_ar && (!arvalid[d] || araddr[d] != p_araddr))
            stab++;
         if (cyc == 1) busy1 = busy[d];
         if (abort_wd && wvalid[d]) begin
            rst[d] = 1;
            start[d] = 0;
            timed_out = 0;
            return;
         end
         if (cyc >= 2 && done[d]) begin
            start[d] = 0;
            timed_out = 0;
            return;
         end
         start[d] = (cyc == 0 || cyc == restart_at);
         if (!stall) begin
            awready[d] = 1; wready[d] = 1; arready[d] = 1;
         end else begin
            awready[d] = (aw_w == 0);
            if (awvalid[d] && aw_w > 0) aw_w--;
            wready[d] = (w_w == 0);
            if (wvalid[d] && w_w > 0) w_w--;
            arready[d] = (ar_w == 0);
            if (arvalid[d] && ar_w > 0) ar_w--;
         end
         if (!bvalid[d] && b_pend > 0) begin
            bvalid[d] = 1;
            bid[d] = ID;
            bresp[d] = (b_cnt == bad_b) ? 2'b10 : 2'b00;
            b_cnt++;
            b_pend--;
         end
         if (rq.size() > 0) begin
            a = (rq[0] + rbeat) & MASK;
            rvalid[d] = 1;
            rid[d] = ID;
            rresp[d] = 2'b00;
            rlast[d] = (rbeat == bl - 1);
            rdata[d] = mem.exists(a) ? mem[a] : 16'h0;
            if (a == bad_word) rdata[d] = rdata[d] ^ 16'h0100;
         end else begin
            rvalid[d] = 0;
            rlast[d] = 0;
         end
         p_awv = awvalid[d];
         p_aw = awvalid[d] && awready[d];
         p_awaddr = awaddr[d];
         p_wv = wvalid[d];
         p_w = wvalid[d] && wready[d];
         p_wdata = wdata[d];
         p_wlast = wlast[d];
         p_b = bvalid[d] && bready[d];
         p_arv = arvalid[d];
         p_ar = arvalid[d] && arready[d];
         p_araddr = araddr[d];
         p_r = rvalid[d] && rready[d];
      end
      start[d] = 0;
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (outs(d) !== 256'h0) begin
            errors++;
            $display("FAIL reset_state[%0d]: got %h want 0", d, outs(d));
         end
      end
      rst[0] = 0;
      rst[1] = 0;
      @(negedge clk);
   endtask

   task automatic test_ideal;
      bit to, b1;
      int bad;
      mem.delete();
      serve(0, 0, -1, -1, -1, 0, to, b1);
      checks++;
      if (to) begin
         errors++;
         $display("FAIL ideal timeout: done low after budget, want 1");
      end
      checks++;
      if (b1 !== 1'b1) begin
         errors++;
         $display("FAIL ideal busy: got %b want 1", b1);
      end
      checks++;
      if ({done[0], pass[0], busy[0]} !== 3'b110) begin
         errors++;
         $display("FAIL ideal done/pass/busy: got %b want 110",
                  {done[0], pass[0], busy[0]});
      end
      checks++;
      if (err_count[0] !== 16'd0) begin
         errors++;
         $display("FAIL ideal err_count: got %0d want 0", err_count[0]);
      end
      bad = (aw_log.size() != 2 || ar_log.size() != 2) ? 1 : 0;
      foreach (aw_log[i]) if (aw_log[i] != i * 4) bad++;
      foreach (ar_log[i]) if (ar_log[i] != i * 4) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL ideal addr: %0d wrong aw/ar addresses, want 0", bad);
      end
      bad = (wl_log.size() != 2) ? 1 : 0;
      foreach (wl_log[i]) if (wl_log[i] != 4 * i + 3) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL ideal wlast: %0d misplaced, want beats 3,7", bad);
      end
      bad = 0;
      for (int a = 0; a < 8; a++)
         if (!mem.exists(a) || mem[a] !== pat_of(0, a)) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL ideal wdata: %0d bad words, want 0", bad);
      end
      checks++;
      if ({awid[0], awlen[0], awsize[0], awburst[0], wstrb[0],
           arid[0], arlen[0], arsize[0], arburst[0]} !==
          {ID, 8'd3, 3'b001, 2'b01, 2'b11, ID, 8'd3, 3'b001, 2'b01}) begin
         errors++;
         $display("FAIL ideal fields: got %h/%h/%h/%h/%h want %h/03/1/1/3",
                  awid[0], awlen[0], awsize[0], awburst[0], wstrb[0], ID);
      end
      checks++;
      if (stab != 0 || proto != 0 || awvalid[0] || wvalid[0] ||
          arvalid[0]) begin
         errors++;
         $display("FAIL ideal protocol: stab %0d proto %0d want 0 0",
                  stab, proto);
      end
   endtask

   task automatic test_rdata_err;
      bit to, b1;
      mem.delete();
      serve(0, 0, 5, -1, -1, 0, to, b1);
      checks++;
      if (to || err_count[0] !== 16'd1 || pass[0] !== 1'b0 ||
          done[0] !== 1'b1) begin
         errors++;
         $display("FAIL rdata_err: to %b err %0d pass %b done %b want 0 1 0 1",
                  to, err_count[0], pass[0], done[0]);
      end
      checks++;
      if (fea[0] !== 22'h5) begin
         errors++;
         $display("FAIL rdata_err addr: got %h want 5", fea[0]);
      end
   endtask

   task automatic test_bresp_err;
      bit to, b1;
      mem.delete();
      serve(0, 0, -1, 1, -1, 0, to, b1);
      checks++;
      if (to || err_count[0] !== 16'd1 || pass[0] !== 1'b0) begin
         errors++;
         $display("FAIL bresp_err: to %b err %0d pass %b want 0 1 0",
                  to, err_count[0], pass[0]);
      end
      checks++;
      if (fea[0] !== 22'(base_of(0) + bl_of(0))) begin
         errors++;
         $display("FAIL bresp_err addr: got %h want %h", fea[0],
                  22'(base_of(0) + bl_of(0)));
      end
   endtask

   task automatic test_back_to_back;
      bit to, b1;
      mem.delete();
      serve(0, 0, 2, -1, -1, 0, to, b1);
      serve(0, 0, -1, -1, -1, 0, to, b1);
      checks++;
      if (to || b1 !== 1'b1 || err_count[0] !== 16'd0 ||
          fea[0] !== 22'h0 || pass[0] !== 1'b1) begin
         errors++;
         $display("FAIL back_to_back: to %b busy %b err %0d addr %h pass %b want 0 1 0 0 1",
                  to, b1, err_count[0], fea[0], pass[0]);
      end
   endtask

   task automatic test_stalls;
      bit to, b1;
      for (int it = 0; it < 6; it++) begin
         int kind = int'($urandom_range(0, 2));
         int word = int'($urandom_range(0, 7));
         int brst = int'($urandom_range(0, 1));
         int bw = (kind == 1) ? word : -1;
         int bb = (kind == 2) ? brst : -1;
         int exp_err = (kind == 0) ? 0 : 1;
         int exp_fea = (kind == 1) ? word :
                       (kind == 2) ? brst * bl_of(0) : 0;
         mem.delete();
         serve(0, 1, bw, bb, int'($urandom_range(3, 12)), 0, to, b1);
         checks++;
         if (to || err_count[0] !== 16'(exp_err) ||
             fea[0] !== 22'(exp_fea) || pass[0] !== (exp_err == 0)) begin
            errors++;
            $display("FAIL stalls[%0d]: to %b err %0d addr %h pass %b want 0 %0d %h %b",
                     it, to, err_count[0], fea[0], pass[0], exp_err,
                     22'(exp_fea), exp_err == 0);
         end
         checks++;
         if (stab != 0 || proto != 0 || aw_log.size() != 2) begin
            errors++;
            $display("FAIL stalls[%0d] protocol: stab %0d proto %0d aw %0d want 0 0 2",
                     it, stab, proto, aw_log.size());
         end
      end
   endtask

   task automatic test_wrap;
      bit to, b1;
      int bad;
      mem.delete();
      serve(1, 0, -1, -1, -1, 0, to, b1);
      checks++;
      if (to || aw_log.size() != 1 || ar_log.size() != 1 ||
          aw_log[0] != 32'h003F_FFFC || ar_log[0] != 32'h003F_FFFC) begin
         errors++;
         $display("FAIL wrap addr: to %b aw %0d ar %0d want 0 3ffffc",
                  to, aw_log.size(), ar_log.size());
      end
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         int a = (base_of(1) + i) & MASK;
         if (!mem.exists(a) || mem[a] !== pat_of(1, a)) bad++;
      end
      checks++;
      if (bad != 0 || wl_log.size() != 1) begin
         errors++;
         $display("FAIL wrap wdata: %0d bad words, %0d wlast, want 0 1",
                  bad, wl_log.size());
      end
      checks++;
      if (pass[1] !== 1'b1 || err_count[1] !== 16'd0 ||
          done[1] !== 1'b1) begin
         errors++;
         $display("FAIL wrap result: pass %b err %0d done %b want 1 0 1",
                  pass[1], err_count[1], done[1]);
      end
   endtask

   task automatic test_reset_midrun;
      bit to, b1;
      mem.delete();
      serve(0, 0, -1, -1, -1, 1, to, b1);
      checks++;
      if (to) begin
         errors++;
         $display("FAIL midrun wd: wvalid never seen, want seen");
      end
      @(negedge clk);
      checks++;
      if (outs(0) !== 256'h0) begin
         errors++;
         $display("FAIL midrun reset: got %h want 0", outs(0));
      end
      bvalid[0] = 0;
      rvalid[0] = 0;
      rlast[0] = 0;
      rst[0] = 0;
      @(negedge clk);
      mem.delete();
      serve(0, 0, -1, -1, -1, 0, to, b1);
      checks++;
      if (to || pass[0] !== 1'b1 || err_count[0] !== 16'd0 ||
          aw_log.size() != 2) begin
         errors++;
         $display("FAIL midrun rerun: to %b pass %b err %0d aw %0d want 0 1 0 2",
                  to, pass[0], err_count[0], aw_log.size());
      end
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         rst[i] = 1; start[i] = 0;
         awready[i] = 0; wready[i] = 0; arready[i] = 0;
         bid[i] = '0; bresp[i] = '0; bvalid[i] = 0;
         rid[i] = '0; rdata[i] = '0; rresp[i] = '0;
         rlast[i] = 0; rvalid[i] = 0;
      end
      test_reset;
      test_ideal;
      test_rdata_err;
      test_bresp_err;
      test_back_to_back;
      test_stalls;
      test_wrap;
      test_reset_midrun;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/axi_burst_tester.md
# axi_burst_tester

AXI4 initiator that exercises the SDRAM controller's 16-bit AXI responder port (`user_*`) with a write-then-readback memory test. On `start` it writes NUM_BURSTS INCR bursts of a deterministic pattern, then reads the same region back, compares every beat and reports error status. It sits beside the SDRAM subsystem as a built-in self-test and bring-up master; its AXI outputs connect one-to-one to the controller's `user_*` inputs.

## Interface
- BASE_ADDR, 22'h000000, first word address of the test region
- BURST_LEN, 16, beats per burst (1..256); `awlen`/`arlen` = BURST_LEN-1
- NUM_BURSTS, 64, bursts per phase (1..65535)
- AXI_ID, 8'h00, ID driven on `awid`/`arid` and expected on `bid`/`rid`
- SEED, 16'hACE1, pattern seed (LFSR seed or address XOR mask)

Ports:
- clk_clk  in  1  sole clock
- reset_reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; ignored unless idle
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  set at test end, held until next accepted start
- pass  out  1  valid when done: 1 iff err_count == 0
- err_count  out  16  saturating error count
- first_err_addr  out  22  word address of first failing beat
- m_awid/awaddr/awlen/awsize/awburst/awvalid  out  8/22/8/3/2/1
- m_awready  in  1
- m_wdata/wstrb/wlast/wvalid  out  16/2/1/1
- m_wready  in  1
- m_bid/bresp/bvalid  in  8/2/1
- m_bready  out  1
- m_arid/araddr/arlen/arsize/arburst/arvalid  out  8/22/8/3/2/1
- m_arready  in  1
- m_rid/rdata/rresp/rlast/rvalid  in  8/16/2/1/1
- m_rready  out  1

## Operation
- Addresses are 16-bit word addresses; burst k starts at BASE_ADDR + k*BURST_LEN, mod 2^22 (wraps silently).
- Constant fields: awsize/arsize = 3'b001, awburst/arburst = 2'b01 (INCR), wstrb = 2'b11.
- FSM: IDLE -> WA -> WD -> WB -> (next burst ? WA : RA) -> RD -> (next burst ? RA : FIN) -> IDLE.
- IDLE: all valids low; accepted start clears err_count, first_err_addr, done; resets pattern generator; enters WA.
- WA: awvalid high until awready; WD: beat i carries pattern(addr+i), wlast on beat BURST_LEN-1; WB: bready high, one B accepted; bresp != 2'b00 or bid != AXI_ID adds 1 error.
- RA: arvalid until arready; pattern generator rewound to its write-phase start state on first RA entry.
- RD: rready high; each beat compared to regenerated pattern; error if rdata mismatch, rresp != 0, rid != AXI_ID, or rlast asserted on wrong beat/missing on last beat; at most one increment per beat.
- first_err_addr latched on first error only (B errors record the burst start address).
- FIN: done=1, busy=0, pass computed; returns to IDLE same cycle.
- err_count saturates at 16'hFFFF.

## Timing
- Reset values: all valids 0, bready 0, rready 0, busy 0, done 0, pass 0, err_count 0, first_err_addr 0, other AXI outputs 0.
- All outputs registered; awvalid rises the cycle after start is sampled.
- Valid, once high, stays high with payload stable until the ready handshake (AXI rule); no combinational ready->valid path.
- With ready always high: one W beat per cycle, one R beat accepted per cycle; one idle cycle between phases.
- start while busy is ignored; reset mid-test aborts immediately to reset values, no drain of outstanding bursts.
- One burst outstanding at a time (no AW/AR pipelining).

## Configuration
- AXI_TESTER_LFSR_EN defined: pattern is 16-bit Fibonacci LFSR (taps 16,14,13,11), loaded with SEED at start and rewound at read phase, stepped once per beat.
- Not defined: pattern(addr) = addr[15:0] ^ SEED.

## Test plan
- Ideal memory model, BURST_LEN=4, NUM_BURSTS=2, BASE_ADDR=0 -> awaddr 0,4; araddr 0,4; 8 W beats, wlast on beats 3 and 7; done=1, pass=1, err_count=0.
- Model corrupts rdata at word 5 -> err_count=1, first_err_addr=22'h5, pass=0.
- Model returns bresp=2'b10 on burst 1 -> err_count=1, first_err_addr=BASE_ADDR+BURST_LEN.
- Random awready/wready/arready stalls 0-7 cycles -> payloads stable while valid high, result pass=1.
- BASE_ADDR=22'h3FFFFC, BURST_LEN=8, NUM_BURSTS=1 -> awaddr 22'h3FFFFC, pattern addresses wrap through 0; pass=1.
- Assert reset_reset during WD, then start -> all outputs at reset values next edge; rerun completes pass=1.
